jtframe_st_arbiter: RTL and testbench

Shares the single status read port of the system-info block (`st_addr` out, `st_dout` in) between two requesters: the OSD debug viewer (port A) and the host/ioctl register reader (port B). It serialises their requests with round-robin arbitration. For each transaction it holds `st_addr` stable for the read-path latency, captures `st_dout` and returns it with a one-cycle acknowledge. It sits between the system-info block and its consumers inside the framework top level.

---
 rtl/jtframe_st_arbiter_if.sv | 9 +
 rtl/jtframe_st_arbiter.sv | 95 +++++++++
 tb/tb_jtframe_st_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/jtframe_st_arbiter_if.sv
// jtframe_st_arbiter_if: one requester port of the status read arbiter.
interface jtframe_st_arbiter_if;
    logic       req;
    logic [7:0] addr;
    logic       ack;
    logic [7:0] dout;
    modport master (output req, addr, input ack, dout);
    modport slave  (input req, addr, output ack, dout);
endinterface

// File: rtl/jtframe_st_arbiter.sv
// jtframe_st_arbiter: round-robin sharing of the system-info status read port
// between the OSD viewer (port a) and the host register reader (port b).
module jtframe_st_arbiter #(
    parameter int         LAT       = 2,
    parameter logic [7:0] IDLE_ADDR = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    jtframe_st_arbiter_if.slave a,
    jtframe_st_arbiter_if.slave b,
    output logic [7:0]          st_addr,
    input  logic [7:0]          st_dout
);
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;
    state_t     state_q, state_d;
    logic       gnt_q, gnt_d, last_q, last_d;
    logic       a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [7:0] addr_q, addr_d, st_addr_q, st_addr_d;
    logic [7:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        st_addr_d = st_addr_q;
        wcnt_d    = wcnt_q;
        a_dout_d  = a_dout_q;
        b_dout_d  = b_dout_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        case (state_q)
            IDLE: if (a.req || b.req) begin
                // on a tie the port that was not served last wins
                gnt_d   = b.req && (!a.req || !last_q);
                addr_d  = gnt_d ? b.addr : a.addr;
                state_d = SETUP;
            end
            SETUP: begin
                st_addr_d = addr_q;
                wcnt_d    = 3'(LAT - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                wcnt_d = wcnt_q == 3'd0 ? wcnt_q : wcnt_q - 3'd1;
                if (wcnt_q == 3'd0) begin
                    a_dout_d = gnt_q ? a_dout_q : st_dout;
                    b_dout_d = gnt_q ? st_dout : b_dout_q;
                    state_d  = DONE;
                end
            end
            default: begin
                // an aborted requester still gets its dout refreshed, just no ack
                a_ack_d   = !gnt_q && a.req;
                b_ack_d   = gnt_q && b.req;
                last_d    = gnt_q;
                st_addr_d = IDLE_ADDR;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b0;
            addr_q    <= 8'h00;
            st_addr_q <= IDLE_ADDR;
            wcnt_q    <= 3'd0;
            a_dout_q  <= 8'h00;
            b_dout_q  <= 8'h00;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            st_addr_q <= st_addr_d;
            wcnt_q    <= wcnt_d;
            a_dout_q  <= a_dout_d;
            b_dout_q  <= b_dout_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
        end
    end

    assign st_addr = st_addr_q;
    assign a.ack   = a_ack_q;
    assign a.dout  = a_dout_q;
    assign b.ack   = b_ack_q;
    assign b.dout  = b_dout_q;
endmodule

// File: tb/tb_jtframe_st_arbiter.sv
// tb_jtframe_st_arbiter: directed checks of the status read arbiter with
// system-info stubs at read latencies 1, 2 and 7.
module tb_jtframe_st_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtframe_st_arbiter_if ia2 (), ib2 (), ia1 (), ib1 (), ia7 (), ib7 ();
    logic [7:0] st_addr2, st_dout2, st_addr1, st_dout1, st_addr7, st_dout7;

    jtframe_st_arbiter #(.LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .a(ia2), .b(ib2), .st_addr(st_addr2), .st_dout(st_dout2));
    jtframe_st_arbiter #(.LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .a(ia1), .b(ib1), .st_addr(st_addr1), .st_dout(st_dout1));
    jtframe_st_arbiter #(.LAT(7)) dut7 (.clk(clk), .rst_n(rst_n), .a(ia7), .b(ib7), .st_addr(st_addr7), .st_dout(st_dout7));

    function automatic logic [7:0] f(input logic [7:0] x);
        return x ^ 8'h77;
    endfunction

    // stubs: data becomes valid exactly LAT cycles after st_addr changes, stale before
    logic [7:0] p2;
    logic [7:0] p7 [6];
    always_ff @(posedge clk) begin
        p2    <= f(st_addr2);
        p7[0] <= f(st_addr7);
        for (int i = 1; i < 6; i++) p7[i] <= p7[i-1];
    end
    assign st_dout2 = p2;
    assign st_dout1 = f(st_addr1);
    assign st_dout7 = p7[5];

    int ca2 = 0, cb2 = 0, ca1 = 0, ca7 = 0;
    always @(negedge clk) begin
        if (ia2.ack) ca2++;
        if (ib2.ack) cb2++;
        if (ia1.ack) ca1++;
        if (ia7.ack) ca7++;
    end

    int tests = 0, failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int w);
        return w == 0 ? ia2.ack : w == 1 ? ib2.ack : w == 2 ? ia1.ack : ia7.ack;
    endfunction

    task automatic wait_ack(input int w, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_of(w) && n < 30);
    endtask

    int n;
    int ph, idx;
    logic [7:0] exp_addr;
    logic [1:0] exp_ack;

    initial begin
        ia2.req = 0; ia2.addr = 0; ib2.req = 0; ib2.addr = 0;
        ia1.req = 0; ia1.addr = 0; ib1.req = 0; ib1.addr = 0;
        ia7.req = 0; ia7.addr = 0; ib7.req = 0; ib7.addr = 0;
        repeat (2) @(negedge clk);
        check("rst_st_addr", st_addr2, 8'h00);
        check("rst_acks", {ia2.ack, ib2.ack}, 2'b00);
        check("rst_douts", {ia2.dout, ib2.dout}, 16'h0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_ack", ca2 + cb2, 0);

        // single read on A
        ia2.addr = 8'h40; ia2.req = 1;
        wait_ack(0, n);
        ia2.req = 0;
        check("single_lat", n, 5);
        check("single_dout", ia2.dout, 8'h37);
        repeat (2) @(negedge clk);
        check("single_acks", {ca2, cb2}, {32'd1, 32'd0});

        // both request continuously: B, A, B, A
        ia2.addr = 8'hC0; ia2.req = 1; ib2.addr = 8'h80; ib2.req = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ph = k % 5;
            idx = (k - 1) / 5;
            exp_addr = (ph >= 2) ? ((idx % 2 == 0) ? 8'h80 : 8'hC0) : 8'h00;
            exp_ack = (ph == 0) ? ((idx % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("tie_addr_%0d", k), st_addr2, exp_addr);
            check($sformatf("tie_ack_%0d", k), {ia2.ack, ib2.ack}, exp_ack);
        end
        ia2.req = 0; ib2.req = 0;
        check("tie_a_dout", ia2.dout, 8'hB7);
        check("tie_b_dout", ib2.dout, 8'hF7);
        repeat (2) @(negedge clk);
        check("tie_acks", {ca2, cb2}, {32'd3, 32'd2});

        // abort: B granted, drops in WAIT, A pending
        ib2.addr = 8'h10; ib2.req = 1;
        @(negedge clk);
        ia2.addr = 8'h20; ia2.req = 1;
        repeat (2) @(negedge clk);
        ib2.req = 0;
        repeat (2) @(negedge clk);
        check("abort_b_dout", ib2.dout, 8'h67);
        check("abort_a_untouched", ia2.dout, 8'hB7);
        check("abort_no_b_ack", cb2, 2);
        wait_ack(0, n);
        ia2.req = 0;
        check("abort_a_lat", n, 5);
        check("abort_a_dout", ia2.dout, 8'h57);
        repeat (2) @(negedge clk);
        check("abort_acks", {ca2, cb2}, {32'd4, 32'd2});

        // address change while granted
        ia2.addr = 8'h41; ia2.req = 1;
        repeat (3) @(negedge clk);
        ia2.addr = 8'h00;
        check("addr_hold_3", st_addr2, 8'h41);
        @(negedge clk);
        check("addr_hold_4", st_addr2, 8'h41);
        @(negedge clk);
        check("addr_ack", ia2.ack, 1'b1);
        ia2.req = 0;
        check("addr_dout", ia2.dout, 8'h36);
        check("addr_idle", st_addr2, 8'h00);
        repeat (2) @(negedge clk);

        // reset in the middle of WAIT
        ia2.addr = 8'h55; ia2.req = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; ia2.req = 0;
        #1;
        check("midrst_st_addr", st_addr2, 8'h00);
        check("midrst_acks", {ia2.ack, ib2.ack}, 2'b00);
        check("midrst_douts", {ia2.dout, ib2.dout}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_ack", {ca2, cb2}, {32'd5, 32'd2});

        // latency sweep
        ia1.addr = 8'h40; ia1.req = 1;
        wait_ack(2, n);
        ia1.req = 0;
        check("lat1_lat", n, 4);
        check("lat1_dout", ia1.dout, 8'h37);
        ia7.addr = 8'h5A; ia7.req = 1;
        wait_ack(3, n);
        ia7.req = 0;
        check("lat7_lat", n, 10);
        check("lat7_dout", ia7.dout, 8'h2D);
        repeat (3) @(negedge clk);
        check("lat_sweep_acks", {ca1, ca7}, {32'd1, 32'd1});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
